// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice: opcodes, ALUOp codes and the control word.
package id_ex_pipe_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    localparam logic [2:0] ALUOP_MEM   = 3'b000;
    localparam logic [2:0] ALUOP_BR    = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_JUMP  = 3'b111;

    typedef struct packed {
        logic       regdst;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       beq;
        logic       bne;
        logic [2:0] aluop;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // A bubble is an all-zero control word: nothing writes, nothing accesses memory.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// Load-use hazard detection between a load in EX and the instruction in ID.
module load_use_detect
    import id_ex_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             id_valid,
    input  logic [2:0]       id_aluop,
    input  logic             id_regdst,
    input  logic             id_memwrite,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    output logic             hazard
);

    logic uses_rs;
    logic uses_rt;

    // Jumps read no registers; rt is a source for R-type, stores and branches.
    assign uses_rs = (id_aluop != ALUOP_JUMP);
    assign uses_rt = id_regdst | id_memwrite | id_beq | id_bne;

    assign hazard = id_valid & ex_valid & ex_memread & (ex_rt != '0) &
                    ((uses_rs & (ex_rt == id_rs)) | (uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, flush and held-flush handling.
// Optional bubble counter enabled by defining STALL_CNT_EN.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
`ifdef STALL_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_regDst,
    input  logic              id_memRead,
    input  logic              id_memtoReg,
    input  logic              id_memWrite,
    input  logic              id_ALUSrc,
    input  logic              id_regWrite,
    input  logic              id_beq,
    input  logic              id_bne,
    input  logic [2:0]        id_ALUOp,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regDst,
    output logic              ex_memRead,
    output logic              ex_memtoReg,
    output logic              ex_memWrite,
    output logic              ex_ALUSrc,
    output logic              ex_regWrite,
    output logic              ex_beq,
    output logic              ex_bne,
    output logic [2:0]        ex_ALUOp,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              pend_flush
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hazard;
    logic  flush_eff;

    assign id_ctrl = '{regdst:   id_regDst,
                       memread:  id_memRead,
                       memtoreg: id_memtoReg,
                       memwrite: id_memWrite,
                       alusrc:   id_ALUSrc,
                       regwrite: id_regWrite,
                       beq:      id_beq,
                       bne:      id_bne,
                       aluop:    id_ALUOp};

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .id_valid    (id_valid),
        .id_aluop    (id_ALUOp),
        .id_regdst   (id_regDst),
        .id_memwrite (id_memWrite),
        .id_beq      (id_beq),
        .id_bne      (id_bne),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (ex_valid),
        .ex_memread  (ex_ctrl.memread),
        .ex_rt       (ex_rt),
        .hazard      (hazard)
    );

    // A flushed ID instruction is discarded anyway, so it never needs a stall.
    assign flush_eff = flush | pend_flush;
    assign stall     = hazard & ~flush_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_BUBBLE;
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            pend_flush <= 1'b0;
        end else if (hold) begin
            // Frozen: remember a flush so it is applied on the first free edge.
            if (flush) pend_flush <= 1'b1;
        end else begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            if (flush_eff) begin
                ex_valid   <= 1'b0;
                ex_ctrl    <= CTRL_BUBBLE;
                pend_flush <= 1'b0;
            end else if (hazard) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_BUBBLE;
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_ctrl;
            end
        end
    end

`ifdef STALL_CNT_EN
    // Only hazard bubbles count; flush bubbles are not stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!hold && !flush_eff && hazard)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

    assign ex_regDst   = ex_ctrl.regdst;
    assign ex_memRead  = ex_ctrl.memread;
    assign ex_memtoReg = ex_ctrl.memtoreg;
    assign ex_memWrite = ex_ctrl.memwrite;
    assign ex_ALUSrc   = ex_ctrl.alusrc;
    assign ex_regWrite = ex_ctrl.regwrite;
    assign ex_beq      = ex_ctrl.beq;
    assign ex_bne      = ex_ctrl.bne;
    assign ex_ALUOp    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios then random traffic against a behavioural model.
module tb_id_ex_pipe;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
`ifdef STALL_CNT_EN
    localparam int CNT_W  = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic hold, flush, id_valid;
    logic id_regDst, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite, id_beq, id_bne;
    logic [2:0] id_ALUOp;
    logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [REG_W-1:0] id_rs, id_rt, id_rd;
    logic stall, ex_valid;
    logic ex_regDst, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUSrc, ex_regWrite, ex_beq, ex_bne;
    logic [2:0] ex_ALUOp;
    logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
    logic pend_flush;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what EX should hold after each edge.
    logic        m_valid;
    logic [10:0] m_ctrl;
    logic [DATA_W-1:0] m_pc4, m_rsd, m_rtd, m_imm;
    logic [REG_W-1:0]  m_rs, m_rt, m_rd;
    logic        m_pend;
    int          m_cnt;

    always #5 clk = ~clk;

    id_ex_pipe #(
        .DATA_W(DATA_W), .REG_W(REG_W)
`ifdef STALL_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_regDst(id_regDst), .id_memRead(id_memRead), .id_memtoReg(id_memtoReg),
        .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc), .id_regWrite(id_regWrite),
        .id_beq(id_beq), .id_bne(id_bne), .id_ALUOp(id_ALUOp),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .stall(stall), .ex_valid(ex_valid),
        .ex_regDst(ex_regDst), .ex_memRead(ex_memRead), .ex_memtoReg(ex_memtoReg),
        .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc), .ex_regWrite(ex_regWrite),
        .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_ALUOp(ex_ALUOp),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .pend_flush(pend_flush)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] id_ctrl_vec();
        return {id_regDst, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc,
                id_regWrite, id_beq, id_bne, id_ALUOp};
    endfunction

    function automatic logic [10:0] ex_ctrl_vec();
        return {ex_regDst, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUSrc,
                ex_regWrite, ex_beq, ex_bne, ex_ALUOp};
    endfunction

    // Load in EX whose destination is a source of the ID instruction.
    function automatic bit model_hazard();
        bit reads_rs, reads_rt, ex_is_load;
        reads_rs   = (id_ALUOp != 3'd7);
        reads_rt   = id_regDst || id_memWrite || id_beq || id_bne;
        ex_is_load = m_ctrl[9];
        return id_valid && m_valid && ex_is_load && (m_rt != 0) &&
               ((reads_rs && m_rt == id_rs) || (reads_rt && m_rt == id_rt));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = 0; m_pc4 = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_pend = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit hz, fl;
        hz = model_hazard();
        fl = flush || m_pend;
        if (hold) begin
            if (flush) m_pend = 1;
        end else begin
            m_pc4 = id_pc4; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            if (fl) begin
                m_valid = 0; m_ctrl = 0; m_pend = 0;
            end else if (hz) begin
                m_valid = 0; m_ctrl = 0; m_cnt++;
            end else begin
                m_valid = id_valid; m_ctrl = id_ctrl_vec();
            end
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_ctrl", ex_ctrl_vec(), m_ctrl);
        chk("ex_data", {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}, {m_pc4, m_rsd, m_rtd, m_imm});
        chk("ex_regs", {ex_rs, ex_rt, ex_rd}, {m_rs, m_rt, m_rd});
        chk("pend_flush", pend_flush, m_pend);
`ifdef STALL_CNT_EN
        chk("stall_cnt", stall_cnt, CNT_W'(m_cnt));
`endif
    endtask

    // Called with clk low and inputs already set; returns at the next falling edge.
    task automatic cycle();
        #1;
        chk("stall", stall, model_hazard() && !(flush || m_pend));
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // kind: 0 R-type, 1 lw, 2 sw, 3 beq, 4 bne, 5 j, 6 addi
    task automatic set_instr(input int kind, input int rs, input int rt, input int rd);
        {id_regDst, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite, id_beq, id_bne} = '0;
        id_ALUOp = 3'b000;
        case (kind)
            0: begin id_regDst = 1; id_regWrite = 1; id_ALUOp = 3'b010; end
            1: begin id_memRead = 1; id_memtoReg = 1; id_ALUSrc = 1; id_regWrite = 1; end
            2: begin id_memWrite = 1; id_ALUSrc = 1; end
            3: begin id_beq = 1; id_ALUOp = 3'b001; end
            4: begin id_bne = 1; id_ALUOp = 3'b001; end
            5: id_ALUOp = 3'b111;
            default: begin id_ALUSrc = 1; id_regWrite = 1; end
        endcase
        id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_rd = REG_W'(rd);
        id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_valid = 1;
    endtask

    initial begin
        rst_n = 0; hold = 0; flush = 0;
        set_instr(0, 0, 0, 0);
        id_valid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", ex_valid, 1'b0);
        chk("reset_ctrl", ex_ctrl_vec(), 11'd0);
        check_outputs();
        rst_n = 1;

        // T1: R-type add passes through in one cycle
        set_instr(0, 8, 9, 10);
        cycle();
        chk("t1_valid", ex_valid, 1'b1);
        chk("t1_ctrl", ex_ctrl_vec(), 11'b100001000_10);
        chk("t1_regs", {ex_rs, ex_rt, ex_rd}, {5'd8, 5'd9, 5'd10});

        // T2: lw rt=8 then add using rs=8: one stall, one bubble, then the add enters
        set_instr(1, 3, 8, 0);
        cycle();
        set_instr(0, 8, 9, 10);
        #1 chk("t2_stall", stall, 1'b1);
        cycle();
        chk("t2_bubble_ctrl", ex_ctrl_vec(), 11'd0);
        chk("t2_bubble_valid", ex_valid, 1'b0);
        #1 chk("t2_stall_gone", stall, 1'b0);
        cycle();
        chk("t2_add_in", {ex_valid, ex_ALUOp}, {1'b1, 3'b010});

        // T3: load to r0 never creates a hazard
        set_instr(1, 3, 0, 0);
        cycle();
        set_instr(0, 0, 0, 4);
        #1 chk("t3_stall", stall, 1'b0);
        cycle();
        chk("t3_valid", ex_valid, 1'b1);

        // T4: flush wins over a hazard; no stall, bubble, not counted
        set_instr(1, 3, 6, 0);
        cycle();
        set_instr(0, 6, 1, 2);
        flush = 1;
        #1 chk("t4_stall", stall, 1'b0);
        cycle();
        flush = 0;
        chk("t4_bubble", {ex_valid, ex_ctrl_vec()}, 12'd0);

        // T5: hold 3 cycles with flush pulsed in the second, then a free edge
        set_instr(0, 1, 2, 3);
        cycle();
        set_instr(6, 4, 5, 0);
        hold = 1;
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        chk("t5_pend_set", pend_flush, 1'b1);
        cycle();
        chk("t5_frozen", {ex_valid, ex_rd}, {1'b1, 5'd3});
        hold = 0;
        cycle();
        chk("t5_bubble", {ex_valid, ex_ctrl_vec(), pend_flush}, 13'd0);

        // T6: asynchronous reset between edges, in the middle of a hold with a flush pending
        set_instr(0, 7, 7, 7);
        cycle();
        hold = 1; flush = 1;
        cycle();
        flush = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("t6_async_valid", ex_valid, 1'b0);
        chk("t6_async_rd", ex_rd, 5'd0);
        check_outputs();
        @(negedge clk);
        hold = 0;
        rst_n = 1;

`ifdef STALL_CNT_EN
        // Counter wraps: 2^CNT_W + 1 hazard bubbles leave a count of one
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            set_instr(1, 2, 5, 0);
            cycle();
            set_instr(0, 5, 1, 9);
            cycle();
            cycle();
        end
        chk("t6_cnt_wrap", stall_cnt, CNT_W'(1));
`endif

        // Random traffic on a tiny register set so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            set_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            id_valid = ($urandom_range(0, 9) != 0);
            hold     = ($urandom_range(0, 6) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            cycle();
        end
        hold = 0; flush = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
